// File: rtl/security_pkg.sv
// Shared types and helpers for the intruder-alarm controller.
// Covers FSM states, zone indices and the sensor-to-zone reduction.
package security_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        ALERT    = 2'd2
    } state_t;

    localparam int ZONE_DOOR        = 0;
    localparam int ZONE_WINDOW      = 1;
    localparam int ZONE_MOTION      = 2;
    localparam int NUM_ZONES        = 3;
    localparam int SENSORS_PER_ZONE = 2;

    // Each zone owns two adjacent sensor bits; a zone is active if either bit is set.
    function automatic logic [NUM_ZONES-1:0] zone_reduce(input logic [5:0] s);
        logic [NUM_ZONES-1:0] z;
        for (int i = 0; i < NUM_ZONES; i++) begin
            z[i] = |s[i*SENSORS_PER_ZONE +: SENSORS_PER_ZONE];
        end
        return z;
    endfunction

    function automatic logic [1:0] zone_count(input logic [NUM_ZONES-1:0] z);
        return {1'b0, z[0]} + {1'b0, z[1]} + {1'b0, z[2]};
    endfunction

endpackage

// File: rtl/security_alert_timer.sv
// Saturating alert-duration counter.
// done_next reports whether the value about to be registered equals the police delay.
module security_alert_timer #(
    parameter int POLICE_DELAY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic done_next
);

    localparam logic [7:0] LIMIT = 8'(POLICE_DELAY);

    logic [7:0] cnt_reg;
    logic [7:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr || load) begin
            cnt_next = 8'd0;
        end else if (en && (cnt_reg != LIMIT)) begin
            cnt_next = cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= 8'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign done_next = (cnt_next == LIMIT);

endmodule

// File: rtl/security_system.sv
// Intruder-alarm controller: arming FSM, zone latching and registered alarm outputs.
// Every output is a flop loaded from next-state values, so no input reaches an output combinationally.
module security_system
    import security_pkg::*;
#(
    parameter int POLICE_DELAY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] s1,
    input  logic       main_sw,
    output logic       alarm,
    output logic       lights,
    output logic       call_to_pol,
    output logic       video_camera
);

    state_t                state_reg, state_next;
    logic [NUM_ZONES-1:0]  zone_seen_reg, zone_seen_next;
    logic [NUM_ZONES-1:0]  zone_now;
    logic                  alarm_reg, alarm_next;
    logic                  lights_reg, lights_next;
    logic                  call_reg, call_next;
    logic                  timer_load, timer_en, timer_done_next;

    assign zone_now = zone_reduce(s1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= DISARMED;
            zone_seen_reg <= '0;
        end else begin
            state_reg     <= state_next;
            zone_seen_reg <= zone_seen_next;
        end
    end

    // Disarm takes precedence over any sensor activity in every state.
    always_comb begin
        state_next     = state_reg;
        zone_seen_next = zone_seen_reg;
        if (!main_sw) begin
            state_next     = DISARMED;
            zone_seen_next = '0;
        end else begin
            unique case (state_reg)
                DISARMED: state_next = ARMED;
                ARMED: begin
                    if (|s1) begin
                        state_next     = ALERT;
                        zone_seen_next = zone_now;
                    end
                end
                ALERT: zone_seen_next = zone_seen_reg | zone_now;
                default: state_next = DISARMED;
            endcase
        end
    end

    assign timer_load = (state_reg == ARMED) && (state_next == ALERT);
    assign timer_en   = (state_reg == ALERT) && (state_next == ALERT);

    security_alert_timer #(
        .POLICE_DELAY(POLICE_DELAY)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (!main_sw),
        .load     (timer_load),
        .en       (timer_en),
        .done_next(timer_done_next)
    );

    // call_to_pol latches once set; leaving ALERT is the only way to drop it.
    always_comb begin
        alarm_next  = (state_next == ALERT);
        lights_next = alarm_next && zone_seen_next[ZONE_MOTION];
        call_next   = alarm_next &&
                      (call_reg || timer_done_next || (zone_count(zone_seen_next) >= 2'd2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_reg  <= 1'b0;
            lights_reg <= 1'b0;
            call_reg   <= 1'b0;
        end else begin
            alarm_reg  <= alarm_next;
            lights_reg <= lights_next;
            call_reg   <= call_next;
        end
    end

    assign alarm        = alarm_reg;
    assign video_camera = alarm_reg;
    assign lights       = lights_reg;
    assign call_to_pol  = call_reg;

endmodule

// File: tb/tb_security_system.sv
// Self-checking bench for security_system: directed scenarios then random traffic,
// compared each cycle against a behavioural alarm model.
module tb_security_system;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] s1 = '0;
    logic       main_sw = 1'b0;
    logic       alarm, lights, call_to_pol, video_camera;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 = off, 1 = armed, 2 = alerting
    int       m_mode = 0;
    int       m_ticks = 0;
    bit [2:0] m_zones = '0;
    bit       e_alarm = 0, e_lights = 0, e_call = 0;

    security_system #(.POLICE_DELAY(P)) dut (
        .clk         (clk),
        .rst         (rst),
        .s1          (s1),
        .main_sw     (main_sw),
        .alarm       (alarm),
        .lights      (lights),
        .call_to_pol (call_to_pol),
        .video_camera(video_camera)
    );

    always #5 clk = ~clk;

    function automatic bit [2:0] zones_of(input bit [5:0] s);
        bit [2:0] z;
        z[0] = (s & 6'b000011) != 0;
        z[1] = (s & 6'b001100) != 0;
        z[2] = (s & 6'b110000) != 0;
        return z;
    endfunction

    task automatic model_edge(input bit r, input bit sw, input bit [5:0] s);
        int nz;
        if (r || !sw) begin
            m_mode  = 0;
            m_zones = '0;
            m_ticks = 0;
            e_call  = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (s != 0) begin
                m_mode  = 2;
                m_zones = zones_of(s);
                m_ticks = 0;
            end
        end else begin
            m_zones = m_zones | zones_of(s);
            if (m_ticks < P) m_ticks++;
        end
        nz       = int'(m_zones[0]) + int'(m_zones[1]) + int'(m_zones[2]);
        e_alarm  = (m_mode == 2);
        e_lights = e_alarm && m_zones[2];
        e_call   = e_alarm && (e_call || (m_ticks == P) || (nz >= 2));
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input string name, input bit r, input bit sw, input bit [5:0] s);
        @(negedge clk);
        rst     = r;
        main_sw = sw;
        s1      = s;
        @(posedge clk);
        model_edge(r, sw, s);
        #1;
        $display("%-10s rst=%0b sw=%0b s1=%06b -> alarm=%0b cam=%0b lights=%0b call=%0b",
                 name, r, sw, s, alarm, video_camera, lights, call_to_pol);
        check({name, ".alarm"},  alarm,        e_alarm);
        check({name, ".camera"}, video_camera, e_alarm);
        check({name, ".lights"}, lights,       e_lights);
        check({name, ".call"},   call_to_pol,  e_call);
    endtask

    initial begin
        bit [6:0] v;
        bit       r;
        bit       sw;
        bit [5:0] s;

        step("reset", 1, 0, 6'h00);
        step("reset", 1, 1, 6'h3f);

        for (int i = 0; i < 128; i++) begin
            v = 7'(i);
            step("sweep", 0, v[6], v[5:0]);
        end

        // Single window trip: call follows after the delay, lights stay dark
        step("disarm", 0, 0, 6'h00);
        step("arm", 0, 1, 6'h00);
        step("trip_win", 0, 1, 6'b000100);
        for (int i = 0; i < P + 2; i++) step("hold_win", 0, 1, 6'h00);

        // Motion trip lights floodlights on the entry edge
        step("disarm", 0, 0, 6'h00);
        step("arm", 0, 1, 6'h00);
        step("trip_mot", 0, 1, 6'b010000);
        for (int i = 0; i < P + 1; i++) step("hold_mot", 0, 1, 6'h00);

        // Two zones at once call police immediately
        step("disarm", 0, 0, 6'h00);
        step("arm", 0, 1, 6'h00);
        step("trip_multi", 0, 1, 6'b000101);
        step("hold_multi", 0, 1, 6'h00);

        // Disarm mid-alert with every sensor active, then a fresh count on re-arm
        step("disarm", 0, 0, 6'h00);
        step("arm", 0, 1, 6'h00);
        step("trip_door", 0, 1, 6'b000001);
        step("cnt1", 0, 1, 6'h00);
        step("cnt2", 0, 1, 6'h00);
        step("disarm_hot", 0, 0, 6'h3f);
        step("rearm", 0, 1, 6'h3f);
        step("retrip", 0, 1, 6'b000010);
        for (int i = 0; i < P + 1; i++) step("recount", 0, 1, 6'h00);

        // Synchronous reset while alerting, inputs still asserting
        step("rst_alert", 1, 1, 6'h3f);
        step("post_rst", 0, 1, 6'h3f);
        step("post_rst", 0, 1, 6'h3f);

        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            sw = ($urandom_range(0, 7) != 0);
            s  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63))
                                             : (($urandom_range(0, 5) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'h00);
            step("random", r, sw, s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/security_system.md
Name: security_system

Overview:
- Intruder-alarm controller for a premises security block.
- Six sensor inputs are grouped into three zones: door, window and motion.
- A main arming switch enables the system; sensors are ignored while disarmed.
- When armed and any sensor trips, it enters a latched alert: alarm, camera and (conditionally) lights, plus a police call after a delay or on multi-zone intrusion.

Parameters:
- POLICE_DELAY, 4, number of clock edges spent in ALERT before call_to_pol asserts; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- s1  input  6  sensor vector, active-high; [1:0] door zone, [3:2] window zone, [5:4] motion zone.
- main_sw  input  1  arming switch; 1 = armed request, 0 = disarm.
- alarm  output  1  siren; registered.
- lights  output  1  floodlights; registered.
- call_to_pol  output  1  police auto-dial request; registered.
- video_camera  output  1  camera record enable; registered.

Behaviour:
- Inputs are treated as synchronous to clk; no synchronisers inside.
- All outputs are flops. There is no combinational path from any input to any output.
- Reset (rst=1 at an edge) has highest priority: state=DISARMED, zone_seen=000, cnt=0, and all outputs 0.
- State machine, 3 states:
  - DISARMED: main_sw=1 -> ARMED. Sensors are ignored on that same edge.
  - ARMED: main_sw=0 -> DISARMED. Otherwise, any s1 bit set -> ALERT. Otherwise stay.
  - ALERT: main_sw=0 -> DISARMED. Otherwise stay (latched; sensor release does not clear it).
- Disarm (main_sw=0 sampled at an edge) clears zone_seen, cnt and all four outputs on that edge, from any state.
- Zone flags: zone(s1) = {|s1[5:4], |s1[3:2], |s1[1:0]}.
  - On the ARMED->ALERT edge: zone_seen <= zone(s1).
  - In ALERT (staying): zone_seen <= zone_seen | zone(s1).
- cnt (8-bit): loaded with 0 on ALERT entry; in ALERT it increments by 1 per edge, saturating at POLICE_DELAY.
- Outputs, evaluated from the next-state values at each edge:
  - alarm = video_camera = (next state == ALERT).
  - lights = next state == ALERT and next zone_seen[2] (motion) = 1. It stays 1 until disarm.
  - call_to_pol is sticky until disarm. It sets when next state == ALERT and either next cnt == POLICE_DELAY, or popcount(next zone_seen) >= 2.
- Latency:
  - Sensor trip sampled at edge N (while ARMED) -> alarm and video_camera high after edge N.
  - call_to_pol high after edge N+POLICE_DELAY, or after edge N if two or more zones trip simultaneously.
- Arming latency: main_sw rises at edge N -> ARMED after N. The earliest sensor trip is effective at edge N+1.
- Sensors active at the moment of arming do not trip until the first edge in ARMED. If still active then, ALERT is entered.
- main_sw=0 together with active sensors: disarm wins.

Decomposition:
- Package security_pkg holds:
  - state enum (DISARMED, ARMED, ALERT);
  - zone index constants (ZONE_DOOR=0, ZONE_WINDOW=1, ZONE_MOTION=2);
  - a zone-reduction function (6-bit s1 -> 3-bit zones).
- One sub-module is natural: security_alert_timer, the saturating cnt with load/enable and a done flag == POLICE_DELAY.
- FSM and output flops stay in security_system.

Test Plan:
- Reset and exhaustive sweep: rst held, then apply {main_sw,s1}=0..127 with main_sw=0 for values 0..63. Required: all outputs 0 throughout values 0..63.
- Arm, then single trip: main_sw=1 for 1 cycle, then s1=000100 for 1 cycle, then s1=0.
  - alarm and video_camera go 1 one edge later; lights stays 0.
  - call_to_pol goes 1 exactly 4 edges after entry and stays 1.
- Motion trip: armed, s1=010000. Required: alarm, video_camera and lights all 1 on the same edge; call_to_pol follows after POLICE_DELAY.
- Multi-zone trip: armed, s1=000101 (door+window) in one cycle. Required: alarm and call_to_pol both 1 on the entry edge.
- Disarm mid-alert: in ALERT with cnt=2, set main_sw=0 with s1=111111. Required: all outputs 0 next edge and state DISARMED. Re-arm gives a fresh count.
- Sync reset mid-alert: rst=1 for one edge while alarm=1. Required: all outputs 0 after that edge, even with main_sw=1 and sensors active.
